cluster_feeder_seq: RTL and testbench
=====================================

Name: cluster_feeder_seq

Overview:
- Drives the parallel-load/shift interface of cluster_feeder, acting as the transmitter side of the feeder's i_pixel_0..7 / i_sel / i_new protocol.
- Pops 8-pixel chunks from a show-ahead input FIFO and issues one parallel load per row, then one serial chunk every FIFO_WIDTH cycles.
- Flags the cycles on which cluster_feeder's KERNEL_SIZE-wide window holds valid pixels.
- Sits between the row line-buffer FIFO and cluster_feeder inside each convolution cluster.

Parameters:
FIFO_WIDTH, 8, pixels per chunk; also the shift period in cycles
KERNEL_SIZE, 5, window width of cluster_feeder; must be <= FIFO_WIDTH
CHUNK_CNT_W, 8, width of the row-length field in chunks

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  pulse: begin a row; sampled only in IDLE
i_row_chunks  in  CHUNK_CNT_W  row length N in chunks; sampled with i_start
i_fifo_data  in  FIFO_WIDTH*8  show-ahead FIFO head; pixel k at bits [8k+7:8k]
i_fifo_valid  in  1  FIFO not empty
o_fifo_pop  out  1  combinational; pop head this cycle
o_pixels  out  FIFO_WIDTH*8  registered chunk to feeder i_pixel_k
o_new  out  1  registered; feeder load strobe
o_sel  out  1  registered; 1 = parallel load, 0 = serial chunk
o_win_valid  out  1  registered; feeder window valid this cycle
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse at row completion
o_err  out  1  sticky error flag

Behaviour:
- Reset is asynchronous: state returns to IDLE and all outputs and counters go to 0, including o_err. This applies mid-row as well; no partial row resumes.
- States:
  - IDLE: waits for i_start.
  - LOAD: issues a chunk at a chunk boundary.
  - SHIFT: counts FIFO_WIDTH-1 cycles between chunks.
  - DRAIN: finishes the trailing windows of the row.
- IDLE, i_start=1:
  - N=0: set o_err, stay in IDLE, no o_done.
  - Otherwise: latch N, clear o_err, go to LOAD with chunk index c=0.
  - i_start is ignored while o_busy=1.
- LOAD, i_fifo_valid=1:
  - o_fifo_pop=1 this cycle.
  - Next cycle: o_pixels=i_fifo_data, o_new=1, o_sel=(c==0).
  - Then go to SHIFT, or to DRAIN if c==N-1.
- LOAD, i_fifo_valid=0:
  - If c==0: wait in LOAD with no pop, o_new=0, no error.
  - If c>0 (underflow mid-row; the feeder cannot stall): set o_err, drop o_win_valid next cycle, go to IDLE, no o_done.
- o_new/o_sel timing: o_new=1 for exactly one cycle per chunk and is 0 otherwise; o_sel=0 whenever o_new=0.
- Chunk period: consecutive o_new pulses are exactly FIFO_WIDTH cycles apart.
- o_pixels holds its value between loads.
- SHIFT: a phase counter runs 1..FIFO_WIDTH-1, then returns to LOAD with c incremented.
- o_win_valid:
  - Rises the cycle after the o_new/o_sel=1 cycle, matching the feeder's 1-cycle output latency.
  - Stays high for exactly W = FIFO_WIDTH*N - KERNEL_SIZE + 1 consecutive cycles.
  - A window counter is the single source of truth for W.
- DRAIN: ends when the window counter reaches W. o_win_valid falls, and o_done pulses in the same cycle the low o_win_valid is presented. Then return to IDLE.
- Width rule: the window counter is CHUNK_CNT_W + log2(FIFO_WIDTH) bits. N=2^CHUNK_CNT_W-1 must not wrap it.
- Simultaneous events: o_done and a new i_start accept in the same cycle is not required. i_start is sampled only in IDLE, one cycle after o_done.

Decomposition:
- Shared package cluster_pkg holds:
  - the seq_state_t enum {IDLE, LOAD, SHIFT, DRAIN}
  - PIXEL_W=8
  - FIFO_WIDTH and KERNEL_SIZE defaults, shared with cluster_feeder and its bench
- Sub-module: none. The phase, chunk and window counters stay inline.

Test Plan:
- N=1, FIFO holds 0xBEEF50B3BEEF50B3 -> one pop; o_new=o_sel=1 for one cycle with o_pixels=0xBEEF50B3BEEF50B3; o_win_valid high for 4 cycles; o_done pulses; feeder window matches bytes [k..k+4] each valid cycle.
- N=3, FIFO preloaded with 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110 -> o_new at cycles t, t+8, t+16 with o_sel 1,0,0; o_win_valid high 20 consecutive cycles; windows equal pixels 0..4 through 19..23.
- Start with FIFO empty, data arrives 5 cycles later, N=2 -> no pop and no o_new while empty; then normal row, 12 valid cycles, o_err=0.
- N=3 with FIFO emptied after chunk 0 -> at cycle t+8 o_err=1, o_win_valid=0 next cycle, o_busy=0, no o_done; the next i_start clears o_err.
- i_start with i_row_chunks=0 -> o_err=1, o_busy stays 0; i_start pulsed mid-row -> ignored, row timing unchanged.
- Assert i_rst mid-SHIFT of an N=4 row -> all outputs 0 immediately (async), IDLE; fresh N=1 row afterwards behaves as in the first scenario.

Source files
------------

// File: rtl/cluster_pkg.sv
// Shared types and defaults for the convolution cluster feeder path.
package cluster_pkg;

  localparam int unsigned PIXEL_W             = 8;
  localparam int unsigned DEFAULT_FIFO_WIDTH  = 8;
  localparam int unsigned DEFAULT_KERNEL_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/cluster_feeder_seq.sv
// Sequencer that feeds 8-pixel chunks from a show-ahead FIFO into cluster_feeder
// and flags the cycles on which the feeder's kernel window holds valid pixels.
module cluster_feeder_seq
  import cluster_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH  = DEFAULT_FIFO_WIDTH,
  parameter int unsigned KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int unsigned CHUNK_CNT_W = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [CHUNK_CNT_W-1:0]        i_row_chunks,
  input  logic [FIFO_WIDTH*PIXEL_W-1:0] i_fifo_data,
  input  logic                          i_fifo_valid,
  output logic                          o_fifo_pop,
  output logic [FIFO_WIDTH*PIXEL_W-1:0] o_pixels,
  output logic                          o_new,
  output logic                          o_sel,
  output logic                          o_win_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int unsigned DATA_W = FIFO_WIDTH * PIXEL_W;
  localparam int unsigned PH_W   = $clog2(FIFO_WIDTH);
  localparam int unsigned WIN_W  = CHUNK_CNT_W + PH_W;

  seq_state_t             state_q, state_d;
  logic [CHUNK_CNT_W-1:0] n_q, n_d;
  logic [CHUNK_CNT_W-1:0] c_q, c_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [DATA_W-1:0]      pixels_q, pixels_d;
  logic                   new_q, new_d;
  logic                   sel_q, sel_d;
  logic                   win_q, win_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   fifo_pop;

  logic [WIN_W-1:0] w_last;
  logic             last_chunk;
  logic             phase_end;

  // Index of the final valid window cycle: FIFO_WIDTH*N - KERNEL_SIZE.
  assign w_last     = WIN_W'(n_q) * WIN_W'(FIFO_WIDTH) - WIN_W'(KERNEL_SIZE);
  assign last_chunk = (c_q == n_q - CHUNK_CNT_W'(1));
  assign phase_end  = (phase_q == PH_W'(FIFO_WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    c_d       = c_q;
    phase_d   = phase_q;
    pixels_d  = pixels_q;
    new_d     = 1'b0;
    sel_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    // Window opens the cycle after the feeder sees the parallel load.
    win_d     = win_q | (new_q & sel_q);
    win_cnt_d = win_q ? win_cnt_q + WIN_W'(1) : win_cnt_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_row_chunks == '0) begin
            err_d = 1'b1;
          end else begin
            n_d       = i_row_chunks;
            c_d       = '0;
            win_cnt_d = '0;
            err_d     = 1'b0;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        if (i_fifo_valid) begin
          fifo_pop = 1'b1;
          pixels_d = i_fifo_data;
          new_d    = 1'b1;
          sel_d    = (c_q == '0);
          phase_d  = PH_W'(1);
          state_d  = last_chunk ? DRAIN : SHIFT;
        end else if (c_q != '0) begin
          // The feeder cannot stall mid-row, so an empty FIFO here aborts it.
          err_d   = 1'b1;
          win_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          phase_d = '0;
          c_d     = c_q + CHUNK_CNT_W'(1);
          state_d = LOAD;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DRAIN: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (win_q && (win_cnt_q == w_last)) begin
          win_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      c_q       <= '0;
      phase_q   <= '0;
      win_cnt_q <= '0;
      pixels_q  <= '0;
      new_q     <= 1'b0;
      sel_q     <= 1'b0;
      win_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      c_q       <= c_d;
      phase_q   <= phase_d;
      win_cnt_q <= win_cnt_d;
      pixels_q  <= pixels_d;
      new_q     <= new_d;
      sel_q     <= sel_d;
      win_q     <= win_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_fifo_pop  = fifo_pop;
  assign o_pixels    = pixels_q;
  assign o_new       = new_q;
  assign o_sel       = sel_q;
  assign o_win_valid = win_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_cluster_feeder_seq.sv
// Scoreboard bench for cluster_feeder_seq: stimulus queues expected chunks and row
// outcomes; a negedge monitor checks what the DUT presents.
module tb_cluster_feeder_seq;
  import cluster_pkg::*;

  localparam int unsigned FW = DEFAULT_FIFO_WIDTH;
  localparam int unsigned KS = DEFAULT_KERNEL_SIZE;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = FW * PIXEL_W;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [CW-1:0] i_row_chunks;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_valid;
  logic          o_fifo_pop;
  logic [DW-1:0] o_pixels;
  logic          o_new, o_sel, o_win_valid, o_busy, o_done, o_err;

  cluster_feeder_seq #(
    .FIFO_WIDTH (FW),
    .KERNEL_SIZE(KS),
    .CHUNK_CNT_W(CW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_row_chunks(i_row_chunks),
    .i_fifo_data (i_fifo_data),
    .i_fifo_valid(i_fifo_valid),
    .o_fifo_pop  (o_fifo_pop),
    .o_pixels    (o_pixels),
    .o_new       (o_new),
    .o_sel       (o_sel),
    .o_win_valid (o_win_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            sel;
  } chunk_t;

  typedef struct {
    bit is_err;
    int w;    // expected window run length for a completed row
    int gap;  // cycles from last chunk strobe to error, 0 = not checked
  } row_t;

  chunk_t        exp_chunks[$];
  row_t          exp_rows[$];
  logic [DW-1:0] fifo[$];
  bit            fifo_hold;
  int            checks   = 0;
  int            failures = 0;

  function automatic void chk(input bit ok, input string name, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endfunction

  task automatic drive_fifo();
    i_fifo_valid = (fifo.size() > 0) && !fifo_hold;
    i_fifo_data  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic tick();
    bit p;
    @(negedge i_clk);
    p = o_fifo_pop;
    @(posedge i_clk);
    #1;
    if (p && fifo.size() > 0) void'(fifo.pop_front());
    i_start = 1'b0;
    drive_fifo();
  endtask

  task automatic add_chunk(input logic [DW-1:0] d, input bit sel);
    chunk_t c;
    c.data = d;
    c.sel  = sel;
    fifo.push_back(d);
    exp_chunks.push_back(c);
  endtask

  task automatic add_random_row(input int n);
    for (int i = 0; i < n; i++) add_chunk({$urandom, $urandom}, (i == 0));
  endtask

  task automatic expect_done(input int n);
    row_t r;
    r.is_err = 1'b0;
    r.w      = FW * n - KS + 1;
    r.gap    = 0;
    exp_rows.push_back(r);
  endtask

  task automatic expect_err(input int gap);
    row_t r;
    r.is_err = 1'b1;
    r.w      = 0;
    r.gap    = gap;
    exp_rows.push_back(r);
  endtask

  task automatic pulse_start(input int n);
    i_row_chunks = CW'(n);
    i_start      = 1'b1;
    drive_fifo();
    tick();
  endtask

  task automatic wait_idle(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (!o_busy) return;
      tick();
    end
    chk(1'b0, name, 64'(o_busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(o_pixels == '0, {tag, "_pixels"}, o_pixels, 64'd0);
    chk(!o_new, {tag, "_new"}, 64'(o_new), 64'd0);
    chk(!o_sel, {tag, "_sel"}, 64'(o_sel), 64'd0);
    chk(!o_win_valid, {tag, "_win"}, 64'(o_win_valid), 64'd0);
    chk(!o_busy, {tag, "_busy"}, 64'(o_busy), 64'd0);
    chk(!o_done, {tag, "_done"}, 64'(o_done), 64'd0);
    chk(!o_err, {tag, "_err"}, 64'(o_err), 64'd0);
  endtask

  // Monitor: compares every presented chunk/window/done/error against the queues.
  int     cyc = 0;
  int     last_new = -1000;
  int     run = 0;
  bit     prev_new, prev_sel, prev_win, prev_err, err_follow;
  chunk_t mc;
  row_t   mr;

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      prev_new   = 1'b0;
      prev_sel   = 1'b0;
      prev_win   = 1'b0;
      prev_err   = 1'b0;
      err_follow = 1'b0;
      run        = 0;
      last_new   = -1000;
    end else begin
      if (err_follow) chk(!o_win_valid, "win_low_after_err", 64'(o_win_valid), 64'd0);
      err_follow = 1'b0;
      chk(o_new || !o_sel, "sel_only_with_new", 64'(o_sel), 64'd0);
      if (o_new) begin
        if (exp_chunks.size() == 0) begin
          chk(1'b0, "unexpected_new", o_pixels, 64'd0);
        end else begin
          mc = exp_chunks.pop_front();
          chk(o_pixels == mc.data, "chunk_pixels", o_pixels, mc.data);
          chk(o_sel == mc.sel, "chunk_sel", 64'(o_sel), 64'(mc.sel));
          if (!mc.sel) chk(cyc - last_new == FW, "chunk_period", 64'(cyc - last_new), 64'(FW));
        end
        last_new = cyc;
      end
      if (o_win_valid && !prev_win)
        chk(prev_new && prev_sel, "win_rise_after_load", {62'd0, prev_new, prev_sel}, 64'd3);
      if (o_win_valid) run++;
      if (o_done) begin
        chk(!o_win_valid, "done_with_win_low", 64'(o_win_valid), 64'd0);
        if (exp_rows.size() == 0) begin
          chk(1'b0, "unexpected_done", 64'd1, 64'd0);
        end else begin
          mr = exp_rows.pop_front();
          chk(!mr.is_err, "done_not_err", 64'd0, 64'(mr.is_err));
          chk(run == mr.w, "win_run_length", 64'(run), 64'(mr.w));
        end
        run = 0;
      end
      if (o_err && !prev_err) begin
        if (exp_rows.size() == 0) begin
          chk(1'b0, "unexpected_err", 64'd1, 64'd0);
        end else begin
          mr = exp_rows.pop_front();
          chk(mr.is_err, "err_expected", 64'd1, 64'(mr.is_err));
          chk(!o_busy, "err_idle", 64'(o_busy), 64'd0);
          chk(!o_done, "err_no_done", 64'(o_done), 64'd0);
          if (mr.gap > 0) chk(cyc - last_new == mr.gap, "err_timing", 64'(cyc - last_new),
                              64'(mr.gap));
        end
        run        = 0;
        err_follow = 1'b1;
      end
      prev_new = o_new;
      prev_sel = o_sel;
      prev_win = o_win_valid;
      prev_err = o_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 0x0, want 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    int n, dly;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_row_chunks = '0;
    fifo_hold    = 1'b0;
    drive_fifo();
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();

    // N=1 single parallel load
    add_chunk(64'hBEEF50B3BEEF50B3, 1'b1);
    expect_done(1);
    pulse_start(1);
    wait_idle(60, "n1_timeout");
    chk(o_pixels == 64'hBEEF50B3BEEF50B3, "pixels_hold", o_pixels, 64'hBEEF50B3BEEF50B3);

    // N=3 preloaded
    add_chunk(64'h0706050403020100, 1'b1);
    add_chunk(64'h0F0E0D0C0B0A0908, 1'b0);
    add_chunk(64'h1716151413121110, 1'b0);
    expect_done(3);
    pulse_start(3);
    wait_idle(80, "n3_timeout");

    // N=2 with FIFO empty for the first 5 cycles
    fifo_hold = 1'b1;
    add_random_row(2);
    expect_done(2);
    pulse_start(2);
    for (int i = 0; i < 5; i++) begin
      chk(!o_fifo_pop, "no_pop_while_empty", 64'(o_fifo_pop), 64'd0);
      chk(o_busy, "busy_while_waiting", 64'(o_busy), 64'd1);
      tick();
    end
    fifo_hold = 1'b0;
    drive_fifo();
    wait_idle(80, "delay_timeout");
    chk(!o_err, "delay_no_err", 64'(o_err), 64'd0);

    // N=3 underflow after chunk 0
    add_chunk(64'hA5A5A5A55A5A5A5A, 1'b1);
    expect_err(FW);
    pulse_start(3);
    wait_idle(80, "underflow_timeout");
    tick();
    chk(o_err, "underflow_err_sticky", 64'(o_err), 64'd1);

    // next start clears the error
    add_random_row(1);
    expect_done(1);
    pulse_start(1);
    chk(!o_err, "start_clears_err", 64'(o_err), 64'd0);
    wait_idle(60, "clear_timeout");

    // zero-length row
    expect_err(0);
    pulse_start(0);
    chk(o_err, "zero_len_err", 64'(o_err), 64'd1);
    chk(!o_busy, "zero_len_not_busy", 64'(o_busy), 64'd0);
    tick();

    // i_start pulsed mid-row is ignored
    add_random_row(3);
    expect_done(3);
    pulse_start(3);
    repeat (6) tick();
    i_row_chunks = '0;
    i_start      = 1'b1;
    tick();
    repeat (4) tick();
    i_row_chunks = CW'(1);
    i_start      = 1'b1;
    tick();
    wait_idle(80, "midstart_timeout");

    // async reset mid-SHIFT of an N=4 row
    add_random_row(4);
    expect_done(4);
    pulse_start(4);
    repeat (11) tick();
    chk(o_busy, "busy_before_reset", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge i_clk);
    exp_chunks.delete();
    exp_rows.delete();
    fifo.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    drive_fifo();
    tick();

    add_chunk(64'hBEEF50B3BEEF50B3, 1'b1);
    expect_done(1);
    pulse_start(1);
    wait_idle(60, "post_reset_timeout");

    // randomized rows
    for (int r = 0; r < 10; r++) begin
      n   = int'($urandom_range(1, 6));
      dly = int'($urandom_range(0, 3));
      fifo_hold = (dly > 0);
      add_random_row(n);
      expect_done(n);
      pulse_start(n);
      repeat (dly) tick();
      fifo_hold = 1'b0;
      drive_fifo();
      wait_idle(FW * n + 40, "rand_timeout");
      repeat (int'($urandom_range(1, 3))) tick();
    end

    // longest row: window counter must not wrap
    add_random_row(255);
    expect_done(255);
    pulse_start(255);
    wait_idle(FW * 255 + 40, "max_row_timeout");

    repeat (4) tick();
    chk(exp_chunks.size() == 0, "leftover_chunks", 64'(exp_chunks.size()), 64'd0);
    chk(exp_rows.size() == 0, "leftover_rows", 64'(exp_rows.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
